spi_controller: RTL
===================

SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 5, meaning clk cycles per SCLK half-period (legal range 2..255; 5 gives 1 MHz SCLK from 10 MHz clk).
REQ-002 SHALL have port clk  input  1  system clock (10 MHz); single clock domain.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request one frame; sampled only when busy=0.
REQ-005 SHALL have port rw  input  1  frame R/W bit (1 = write).
REQ-006 SHALL have port addr  input  7  frame address.
REQ-007 SHALL have port wdata  input  8  frame data.
REQ-008 SHALL have port busy  output  1  frame in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse at frame completion.
REQ-010 SHALL have port rdata  output  8  captured CIPO byte.
REQ-011 SHALL have port sclk  output  1  SPI clock, Mode 0, idle low.
REQ-012 SHALL have port copi  output  1  SPI data out, MSB first.
REQ-013 SHALL have port ncs  output  1  chip select, active low, idle high.
REQ-014 SHALL have port cipo  input  1  SPI data in.

Function
REQ-015 SHALL implement FSM states IDLE, SETUP, SHIFT, HOLD, GAP.
REQ-016 In IDLE with start=1 SHALL latch {rw,addr,wdata} into a 16-bit frame and enter SETUP; inputs are ignored afterwards until the frame ends.
REQ-017 SHALL hold busy=1 from the cycle after acceptance until the last GAP cycle inclusive.
REQ-018 SHALL ignore start while busy=1, with no queuing.
REQ-019 SETUP SHALL last HALF_PERIOD cycles with ncs=0, sclk=0 and copi=frame[15].
REQ-020 SHIFT SHALL produce exactly 16 SCLK periods, each consisting of HALF_PERIOD cycles low followed by HALF_PERIOD cycles high.
REQ-021 copi SHALL change only on the cycle where sclk falls, advancing to the next bit (bit 15 first, bit 0 last), and SHALL be stable across every rising edge.
REQ-022 After the 16th high phase, sclk SHALL return low and the FSM SHALL enter HOLD, keeping ncs=0 for HALF_PERIOD cycles.
REQ-023 The total ncs-low time SHALL be exactly 34*HALF_PERIOD cycles.
REQ-024 GAP SHALL hold ncs=1, sclk=0 and copi=0 for 2*HALF_PERIOD cycles.
REQ-025 On the cycle after GAP, the FSM SHALL enter IDLE with done=1 for exactly one cycle and busy=0.
REQ-026 A start asserted in the done cycle SHALL be accepted, so back-to-back frames are legal.
REQ-027 SHALL use a half-period counter of ceil(log2(HALF_PERIOD+1)) bits and a 5-bit bit counter (0..16); neither counter SHALL wrap within a frame.
REQ-028 In IDLE, sclk=0, ncs=1 and copi=0.

Reset
REQ-029 While rst=1 at a clk edge, the block SHALL enter IDLE with sclk=0, ncs=1, copi=0, busy=0, done=0 and rdata=0x00.
REQ-030 A reset mid-frame SHALL abort the frame without a done pulse, and ncs SHALL be high on the first cycle after the reset edge.

Configuration
REQ-031 The macro SPI_CTRL_READBACK_EN SHALL control the readback feature.
REQ-032 With SPI_CTRL_READBACK_EN defined, the block SHALL sample cipo on the clk cycle of each sclk rising edge for bits 7..0 (rising edges 9..16), shift it MSB first into rdata, and update rdata only at the done cycle so it is stable otherwise.
REQ-033 Without SPI_CTRL_READBACK_EN, the cipo port SHALL remain but be unused, rdata SHALL be constant 0x00, and no capture logic SHALL exist.

Verification
REQ-034 Write frame: HALF_PERIOD=5, rw=1, addr=0x04, wdata=0x80 -> copi sampled at the 16 rising edges = 0x8480, ncs low for 170 cycles, done 1 cycle after 10 GAP cycles.
REQ-035 Ignore while busy: start pulsed again mid-frame with addr=0x01 -> still a single frame, bits = first request only, exactly one done pulse.
REQ-036 Back-to-back: start held high through the done cycle with a second frame 0x0155 -> the second ncs falling edge occurs the cycle after done and the copi stream = 0x0155.
REQ-037 Readback (macro on): cipo driven 0xA5 MSB first during the data phase -> rdata=0xA5 at done; with the macro off, rdata=0x00.
REQ-038 Reset mid-frame: rst asserted after rising edge 7 -> next cycle ncs=1, sclk=0, busy=0, no done; a new start then produces a clean 16-bit frame.
REQ-039 HALF_PERIOD=2 boundary: frame 0xFFFF -> 16 rising edges, each sclk phase 2 cycles, ncs low for 68 cycles, copi never toggles.

Source files
------------

// File: rtl/spi_controller.sv
// ============================================================================
// spi_controller
// ----------------------------------------------------------------------------
// Purpose:
//   Single-frame SPI controller (Mode 0, MSB first). A frame is 16 bits:
//   {rw, addr[6:0], wdata[7:0]}. One request produces one chip-select window:
//     SETUP  : ncs low, sclk low, first bit presented on copi (one half-period)
//     SHIFT  : 16 sclk periods, low half then high half each
//     HOLD   : ncs still low, sclk low (one half-period)
//     GAP    : ncs high, everything quiet (two half-periods)
//   after which the controller returns to IDLE and pulses done for one cycle.
//   Total ncs-low time is 34 half-periods.
//
// Parameters:
//   HALF_PERIOD  clk cycles per sclk half-period (legal range 2..255)
//
// Ports:
//   clk    in   system clock, single clock domain
//   rst    in   synchronous active-high reset
//   start  in   request one frame; looked at only while idle
//   rw     in   frame R/W bit (1 = write)
//   addr   in   7-bit frame address
//   wdata  in   8-bit frame data
//   busy   out  frame in progress (cycle after acceptance through last GAP cycle)
//   done   out  one-cycle pulse when the frame has fully completed
//   rdata  out  byte captured from cipo during the data phase
//   sclk   out  SPI clock, idle low
//   copi   out  SPI data out
//   ncs    out  SPI chip select, active low
//   cipo   in   SPI data in
//
// Build option:
//   SPI_CTRL_READBACK_EN  when defined, cipo is sampled on the rising sclk
//                         edges of the data byte (edges 9..16) and the byte
//                         is published on rdata at the done cycle. When not
//                         defined, rdata is tied to 0x00 and cipo is ignored.
// ============================================================================
module spi_controller #(
    parameter int HALF_PERIOD = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       sclk,
    output logic       copi,
    output logic       ncs,
    input  logic       cipo
);

    // Half-period counter only ever needs to reach HALF_PERIOD-1; the GAP
    // state is built from two half-periods so it never needs a wider count.
    localparam int             CW      = $clog2(HALF_PERIOD + 1);
    localparam logic [CW-1:0]  HP_LAST = CW'(HALF_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    state_t         state_q,   state_d;
    logic [CW-1:0]  hp_cnt_q,  hp_cnt_d;
    logic [4:0]     bit_cnt_q, bit_cnt_d;
    logic           phase_q,   phase_d;
    logic [15:0]    shift_q,   shift_d;
    logic           done_q,    done_d;
    logic           sclk_q,    sclk_d;
    logic           copi_q,    copi_d;
    logic           ncs_q,     ncs_d;
    logic           hp_last;
    logic           cs_active_d;

    assign hp_last = (hp_cnt_q == HP_LAST);

    // ------------------------------------------------------------------------
    // State and datapath registers.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            hp_cnt_q  <= '0;
            bit_cnt_q <= '0;
            phase_q   <= 1'b0;
            shift_q   <= '0;
            done_q    <= 1'b0;
            sclk_q    <= 1'b0;
            copi_q    <= 1'b0;
            ncs_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            hp_cnt_q  <= hp_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            phase_q   <= phase_d;
            shift_q   <= shift_d;
            done_q    <= done_d;
            sclk_q    <= sclk_d;
            copi_q    <= copi_d;
            ncs_q     <= ncs_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic.
    // phase_q selects the low (0) or high (1) half of an sclk period in SHIFT,
    // and the first or second half of the GAP. bit_cnt_q counts completed
    // sclk periods and ends a frame at 16.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        hp_cnt_d  = hp_cnt_q;
        bit_cnt_d = bit_cnt_q;
        phase_d   = phase_q;
        shift_d   = shift_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d   = {rw, addr, wdata};
                    hp_cnt_d  = '0;
                    bit_cnt_d = '0;
                    phase_d   = 1'b0;
                    state_d   = SETUP;
                end
            end

            SETUP: begin
                if (hp_last) begin
                    hp_cnt_d = '0;
                    phase_d  = 1'b0;
                    state_d  = SHIFT;
                end else begin
                    hp_cnt_d = hp_cnt_q + 1'b1;
                end
            end

            SHIFT: begin
                if (!hp_last) begin
                    hp_cnt_d = hp_cnt_q + 1'b1;
                end else begin
                    hp_cnt_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        // End of a high half: sclk falls next cycle.
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        phase_d   = 1'b0;
                        if (bit_cnt_q == 5'd15) begin
                            // Last bit stays on copi through HOLD.
                            state_d = HOLD;
                        end else begin
                            shift_d = {shift_q[14:0], 1'b0};
                        end
                    end
                end
            end

            HOLD: begin
                if (hp_last) begin
                    hp_cnt_d = '0;
                    phase_d  = 1'b0;
                    state_d  = GAP;
                end else begin
                    hp_cnt_d = hp_cnt_q + 1'b1;
                end
            end

            GAP: begin
                if (!hp_last) begin
                    hp_cnt_d = hp_cnt_q + 1'b1;
                end else begin
                    hp_cnt_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // SPI pin decode. Pins are registered from the next-state values so they
    // line up with the state registers yet come straight off flops, avoiding
    // decode glitches on sclk and ncs.
    // ------------------------------------------------------------------------
    always_comb begin
        cs_active_d = 1'b0;
        sclk_d      = 1'b0;
        copi_d      = 1'b0;
        ncs_d       = 1'b1;

        cs_active_d = (state_d == SETUP) || (state_d == SHIFT) || (state_d == HOLD);
        ncs_d       = !cs_active_d;
        sclk_d      = (state_d == SHIFT) && phase_d;
        copi_d      = cs_active_d ? shift_d[15] : 1'b0;
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign sclk = sclk_q;
    assign copi = copi_q;
    assign ncs  = ncs_q;

`ifdef SPI_CTRL_READBACK_EN
    // ------------------------------------------------------------------------
    // Readback capture. cipo is sampled in the first cycle of each high
    // sclk half for periods 8..15 (rising edges 9..16). The assembled byte is
    // only published when done fires so rdata never shows a partial byte.
    // ------------------------------------------------------------------------
    logic [7:0] rx_q,    rx_d;
    logic [7:0] rdata_q, rdata_d;
    logic       rise_cycle;

    assign rise_cycle = (state_q == SHIFT) && phase_q && (hp_cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_q    <= '0;
            rdata_q <= '0;
        end else begin
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        rx_d    = rx_q;
        rdata_d = rdata_q;
        if (rise_cycle && (bit_cnt_q >= 5'd8)) begin
            rx_d = {rx_q[6:0], cipo};
        end
        if (done_d) begin
            rdata_d = rx_q;
        end
    end

    assign rdata = rdata_q;
`else
    // Readback disabled: the input pin stays on the interface but is unused.
    logic cipo_unused;
    assign cipo_unused = cipo;
    assign rdata       = 8'h00;
`endif

endmodule
